mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Two-client arbiter between the cache layer (e.g. I-cache = client 0, D-cache = client 1) and the single DRAM
//  system bus. Grants one whole bus transaction at a time: address beat + 8 write-data beats, or address beat +
//  8 read-response beats. Pure forwarding of reqcyc/reqack and respcyc/respack handshakes; no data buffering.
// PARAMETERS
//  BUS_DATA_WIDTH  64  width of req/resp data and address beats
//  BUS_TAG_WIDTH   13  width of reqtag/resptag; bit WRITE_BIT marks a write transaction
//  WRITE_BIT       12  tag bit index; value `SYSBUS_WRITE` = write, otherwise read
//  BEATS           8   data beats per transaction (one 512-bit line)
// PORTS
//  clk          in   1    clock
//  reset        in   1    synchronous, active-high
//  cN_reqcyc    in   1    client N (N=0,1) request valid (address beat, then write-data beats)
//  cN_reqack    out  1    forwarded m_bus_reqack, owner only
//  cN_req       in   BDW  client N address / write data
//  cN_reqtag    in   BTW  client N tag (sampled with address beat)
//  cN_respcyc   out  1    forwarded m_bus_respcyc, owner only, read transactions only
//  cN_respack   in   1    client N response accept
//  cN_resp      out  BDW  forwarded m_bus_resp (0 when not owner)
//  cN_resptag   out  BTW  forwarded m_bus_resptag (0 when not owner)
//  m_bus_reqcyc out  1    to DRAM: owner's reqcyc in REQ/WDATA, else 0
//  m_bus_reqack in   1    DRAM accepts current request beat
//  m_bus_req    out  BDW  owner's cN_req, else 0
//  m_bus_reqtag out  BTW  owner's cN_reqtag, else 0
//  m_bus_respcyc in  1    DRAM response beat valid
//  m_bus_respack out 1    owner's cN_respack in RDATA, else 0
//  m_bus_resp   in   BDW  DRAM response data
//  m_bus_resptag in  BTW  DRAM response tag
//  busy         out  1    1 in any state other than IDLE
//  owner        out  1    current/last granted client
// BEHAVIOUR
//  Reset: state=IDLE, owner=1 (so client 0 wins first tie), beat=0, is_wr=0; all outputs 0 except owner=1.
//  FSM IDLE -> REQ -> {WDATA | RDATA} -> IDLE. State, owner, beat counter (3 bits), is_wr are registered.
//  IDLE: no forwarding. If exactly one cN_reqcyc=1, owner<=N; if both, owner<=~owner (round robin); -> REQ.
//   Grant costs 1 cycle: DRAM sees the address beat no earlier than the cycle after reqcyc rises.
//  REQ: forward owner's req/tag/reqcyc; on m_bus_reqack=1 latch is_wr = (reqtag[WRITE_BIT]==`SYSBUS_WRITE`),
//   beat<=0, -> WDATA if write else RDATA. If owner drops reqcyc before ack -> IDLE (abort, no beats).
//  WDATA: forward owner's req/reqcyc; each cycle with reqcyc&&m_bus_reqack counts a beat; on beat 7 -> IDLE.
//   Tag outputs hold the tag presented during REQ? No: m_bus_reqtag forwards live owner tag every cycle.
//  RDATA: cN_respcyc/resp/resptag = m_bus_* for owner; m_bus_respack = owner's respack; beat counts on
//   m_bus_respcyc && respack; on beat 7 -> IDLE. Non-owner sees respcyc=0, resp=0, resptag=0.
//  m_bus_respcyc outside RDATA is never acked (m_bus_respack=0). Non-owner reqcyc is held off (reqack=0).
//  Ownership is locked for the whole transaction; a request arriving mid-transaction waits for IDLE.
//  Back-to-back: after final beat, IDLE re-arbitrates next cycle; alternating clients when both request.
//  Reset mid-transaction: immediate return to reset values; DRAM side sees reqcyc/respack drop same edge.
//  Handshake forwarding is combinational (no added latency per beat); only grant adds one cycle.
// CONFIGURATION
//  MEM_BUS_ARB_PERF_EN defined: adds outputs grant_cnt0, grant_cnt1 (32 bits each), incremented on each
//   transaction completion (final beat) for that client, wrap at 2^32, cleared by reset; plus
//   wait_cnt (32 bits) counting cycles where a non-owner holds reqcyc=1 while busy=1.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  sysbus_pkg: `SYSBUS_WRITE` value, WRITE_BIT, BEATS, arb_state_t enum {IDLE,REQ,WDATA,RDATA}.
//  Sub-module rr_arbiter2: inputs req[1:0], last; output grant index; purely combinational pick,
//   instantiated once in IDLE decision path. Mux/forward logic and FSM stay in mem_bus_arbiter.
// TESTING
//  1 c0 read (tag bit12 read), DRAM acks addr then sends 8 beats 0x10..0x17 -> c0 gets 8 beats in order,
//    c1_respcyc=0 throughout, busy drops cycle after 8th ack.
//  2 c1 write addr 0x1000 + data 0xA0..0xA7, DRAM acks each beat with 1-cycle gaps -> m_bus_req sequence
//    0x1000,0xA0..0xA7, then IDLE; no m_bus_respack ever asserted.
//  3 c0,c1 reqcyc rise same cycle after reset -> c0 granted first; after completion c1 granted; repeat -> c0.
//  4 c1 requests while c0 read in beat 3 -> c1_reqack stays 0 until c0 beat 7; c1 granted next IDLE.
//  5 reset asserted during WDATA beat 4 -> next cycle busy=0, owner=1, m_bus_reqcyc=0; fresh c1 read completes.
//  6 c0 drops reqcyc in REQ without ack -> IDLE, no beats; with MEM_BUS_ARB_PERF_EN grant_cnt0 unchanged.

Source files
------------

// File: rtl/sysbus_pkg.sv
// sysbus_pkg: shared system-bus constants and arbiter state encoding.
// SYSBUS_WRITE is the tag value at WRITE_BIT that marks a write.
`ifndef SYSBUS_WRITE
`define SYSBUS_WRITE 1'b1
`endif

package sysbus_pkg;
  localparam int   WRITE_BIT     = 12;
  localparam int   BEATS         = 8;
  localparam logic SYSBUS_WR_VAL = `SYSBUS_WRITE;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WDATA,
    RDATA
  } arb_state_t;
endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// rr_arbiter2: two-way round-robin pick, purely combinational.
// On a tie the client that was not granted last wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);
  always_comb begin
    grant = last;
    unique case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last;
      default: grant = last;
    endcase
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-client arbiter onto the DRAM system bus.
// Optional perf counters under `MEM_BUS_ARB_PERF_EN.
module mem_bus_arbiter
  import sysbus_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int WRITE_BIT      = sysbus_pkg::WRITE_BIT,
  parameter int BEATS          = sysbus_pkg::BEATS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      c0_reqcyc,
  output logic                      c0_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] c0_req,
  input  logic [BUS_TAG_WIDTH-1:0]  c0_reqtag,
  output logic                      c0_respcyc,
  input  logic                      c0_respack,
  output logic [BUS_DATA_WIDTH-1:0] c0_resp,
  output logic [BUS_TAG_WIDTH-1:0]  c0_resptag,
  input  logic                      c1_reqcyc,
  output logic                      c1_reqack,
  input  logic [BUS_DATA_WIDTH-1:0] c1_req,
  input  logic [BUS_TAG_WIDTH-1:0]  c1_reqtag,
  output logic                      c1_respcyc,
  input  logic                      c1_respack,
  output logic [BUS_DATA_WIDTH-1:0] c1_resp,
  output logic [BUS_TAG_WIDTH-1:0]  c1_resptag,
  output logic                      m_bus_reqcyc,
  input  logic                      m_bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] m_bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  m_bus_reqtag,
  input  logic                      m_bus_respcyc,
  output logic                      m_bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] m_bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  m_bus_resptag,
  output logic                      busy,
  output logic                      owner
`ifdef MEM_BUS_ARB_PERF_EN
  ,
  output logic [31:0]               grant_cnt0,
  output logic [31:0]               grant_cnt1,
  output logic [31:0]               wait_cnt
`endif
);
  localparam logic [2:0] LAST = 3'(BEATS - 1);

  arb_state_t state_q, state_d;
  logic       owner_q, owner_d;
  logic       is_wr_q, is_wr_d;
  logic [2:0] beat_q, beat_d;
  logic       pick, done;
  logic       fwd_req, fwd_rsp;

  logic                      o_cyc, o_rack;
  logic [BUS_DATA_WIDTH-1:0] o_req;
  logic [BUS_TAG_WIDTH-1:0]  o_tag;

  assign o_cyc  = owner_q ? c1_reqcyc  : c0_reqcyc;
  assign o_rack = owner_q ? c1_respack : c0_respack;
  assign o_req  = owner_q ? c1_req     : c0_req;
  assign o_tag  = owner_q ? c1_reqtag  : c0_reqtag;

  assign fwd_req = (state_q == REQ) || (state_q == WDATA);
  assign fwd_rsp = (state_q == RDATA);

  rr_arbiter2 u_rr (
    .req   ({c1_reqcyc, c0_reqcyc}),
    .last  (owner_q),
    .grant (pick)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    is_wr_d = is_wr_q;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (c0_reqcyc || c1_reqcyc) begin
          owner_d = pick;
          state_d = REQ;
        end
      end
      REQ: begin
        // owner withdrew before the address beat was taken
        if (!o_cyc) begin
          state_d = IDLE;
        end else if (m_bus_reqack) begin
          is_wr_d = (o_tag[WRITE_BIT] == SYSBUS_WR_VAL);
          beat_d  = '0;
          state_d = is_wr_d ? WDATA : RDATA;
        end
      end
      WDATA: begin
        if (o_cyc && m_bus_reqack) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == LAST) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      RDATA: begin
        if (m_bus_respcyc && o_rack) begin
          beat_d = beat_q + 3'd1;
          if (beat_q == LAST) begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      beat_q  <= '0;
      is_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      is_wr_q <= is_wr_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

  assign m_bus_reqcyc  = fwd_req & o_cyc;
  assign m_bus_req     = fwd_req ? o_req : '0;
  assign m_bus_reqtag  = fwd_req ? o_tag : '0;
  assign m_bus_respack = fwd_rsp & o_rack;

  assign c0_reqack  = fwd_req & ~owner_q & m_bus_reqack;
  assign c1_reqack  = fwd_req &  owner_q & m_bus_reqack;
  assign c0_respcyc = fwd_rsp & ~owner_q & m_bus_respcyc;
  assign c1_respcyc = fwd_rsp &  owner_q & m_bus_respcyc;
  assign c0_resp    = (fwd_rsp & ~owner_q) ? m_bus_resp    : '0;
  assign c1_resp    = (fwd_rsp &  owner_q) ? m_bus_resp    : '0;
  assign c0_resptag = (fwd_rsp & ~owner_q) ? m_bus_resptag : '0;
  assign c1_resptag = (fwd_rsp &  owner_q) ? m_bus_resptag : '0;

`ifdef MEM_BUS_ARB_PERF_EN
  logic [31:0] gc0_q, gc0_d, gc1_q, gc1_d, wait_q, wait_d;
  logic        n_cyc;

  assign n_cyc = owner_q ? c0_reqcyc : c1_reqcyc;

  always_comb begin
    gc0_d  = gc0_q + 32'(done & ~owner_q);
    gc1_d  = gc1_q + 32'(done &  owner_q);
    wait_d = wait_q + 32'(busy & n_cyc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gc0_q  <= '0;
      gc1_q  <= '0;
      wait_q <= '0;
    end else begin
      gc0_q  <= gc0_d;
      gc1_q  <= gc1_d;
      wait_q <= wait_d;
    end
  end

  assign grant_cnt0 = gc0_q;
  assign grant_cnt1 = gc1_q;
  assign wait_cnt   = wait_q;
`endif
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench for mem_bus_arbiter.
// Drives both clients and a DRAM model; expected beats queued up front.
module tb_mem_bus_arbiter;
  localparam logic [12:0] TAG_WR = 13'h1003;
  localparam logic [12:0] TAG_RD = 13'h0003;
  localparam logic [12:0] RTAG   = 13'h0055;
  localparam logic [63:0] OTH_A  = 64'h0000_0000_0000_0ABC;

  logic        clk = 1'b0;
  logic        reset;
  logic        c0_reqcyc, c0_reqack, c0_respcyc, c0_respack;
  logic [63:0] c0_req, c0_resp;
  logic [12:0] c0_reqtag, c0_resptag;
  logic        c1_reqcyc, c1_reqack, c1_respcyc, c1_respack;
  logic [63:0] c1_req, c1_resp;
  logic [12:0] c1_reqtag, c1_resptag;
  logic        m_bus_reqcyc, m_bus_reqack, m_bus_respcyc, m_bus_respack;
  logic [63:0] m_bus_req, m_bus_resp;
  logic [12:0] m_bus_reqtag, m_bus_resptag;
  logic        busy, owner;
`ifdef MEM_BUS_ARB_PERF_EN
  logic [31:0] grant_cnt0, grant_cnt1, wait_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int gc0 = 0;
  int gc1 = 0;
  logic [63:0] req_q[$];
  logic [63:0] rsp_q[$];

  mem_bus_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .c0_reqcyc     (c0_reqcyc),
    .c0_reqack     (c0_reqack),
    .c0_req        (c0_req),
    .c0_reqtag     (c0_reqtag),
    .c0_respcyc    (c0_respcyc),
    .c0_respack    (c0_respack),
    .c0_resp       (c0_resp),
    .c0_resptag    (c0_resptag),
    .c1_reqcyc     (c1_reqcyc),
    .c1_reqack     (c1_reqack),
    .c1_req        (c1_req),
    .c1_reqtag     (c1_reqtag),
    .c1_respcyc    (c1_respcyc),
    .c1_respack    (c1_respack),
    .c1_resp       (c1_resp),
    .c1_resptag    (c1_resptag),
    .m_bus_reqcyc  (m_bus_reqcyc),
    .m_bus_reqack  (m_bus_reqack),
    .m_bus_req     (m_bus_req),
    .m_bus_reqtag  (m_bus_reqtag),
    .m_bus_respcyc (m_bus_respcyc),
    .m_bus_respack (m_bus_respack),
    .m_bus_resp    (m_bus_resp),
    .m_bus_resptag (m_bus_resptag),
    .busy          (busy),
    .owner         (owner)
`ifdef MEM_BUS_ARB_PERF_EN
    ,
    .grant_cnt0    (grant_cnt0),
    .grant_cnt1    (grant_cnt1),
    .wait_cnt      (wait_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_all();
    c0_reqcyc = 0; c0_req = '0; c0_reqtag = '0; c0_respack = 0;
    c1_reqcyc = 0; c1_req = '0; c1_reqtag = '0; c1_respack = 0;
    m_bus_reqack = 0; m_bus_respcyc = 0;
    m_bus_resp = '0; m_bus_resptag = '0;
  endtask

  task automatic drv(input bit cl, input logic cyc, input logic [63:0] d,
                     input logic [12:0] t, input logic rack);
    if (cl) begin
      c1_reqcyc = cyc; c1_req = d; c1_reqtag = t; c1_respack = rack;
    end else begin
      c0_reqcyc = cyc; c0_req = d; c0_reqtag = t; c0_respack = rack;
    end
  endtask

  // One whole transaction for client cl; called just after a negedge.
  task automatic xact(input bit cl, input bit wr, input logic [63:0] addr,
                      input logic [63:0] d0, input bit gap,
                      input int oth_at, input int rst_at);
    int k, r, n, vio;
    logic [63:0] e;
    k = 0; r = 0; n = 0; vio = 0;
    req_q.delete(); rsp_q.delete();
    req_q.push_back(addr);
    for (int i = 0; i < 8; i++) begin
      if (wr) req_q.push_back(d0 + 64'(i));
      else    rsp_q.push_back(d0 + 64'(i));
    end
    while (n < 200 && (wr ? (k < 9) : (r < 8))) begin
      if (k == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 1);
        chk("rst_mcyc", m_bus_reqcyc, 0);
        idle_all();
        gc0 = 0; gc1 = 0;
        req_q.delete(); rsp_q.delete();
        return;
      end
      drv(cl, wr ? (k < 9) : (k == 0),
          (k == 0) ? addr : d0 + 64'(k - 1),
          wr ? TAG_WR : TAG_RD, 1'b1);
      if (oth_at >= 0 && (wr ? k : r) >= oth_at)
        drv(!cl, 1'b1, OTH_A, TAG_RD, 1'b0);
      m_bus_respcyc = 1'b1;
      m_bus_resp    = d0 + 64'(r);
      m_bus_resptag = RTAG;
      m_bus_reqack  = 1'b0;
      #1;
      m_bus_reqack = m_bus_reqcyc && (!gap || n[0]);
      #1;
      if (n == 0) chk("grant_lat", m_bus_reqcyc, 0);
      if (cl ? (c0_reqack | c0_respcyc) : (c1_reqack | c1_respcyc)) vio++;
      if (m_bus_respack !== (!wr && k > 0)) vio++;
      if (m_bus_reqcyc && m_bus_reqack) begin
        if (!(cl ? c1_reqack : c0_reqack)) vio++;
        if (k == 0) chk("m_tag", m_bus_reqtag, wr ? TAG_WR : TAG_RD);
        e = req_q.size() != 0 ? req_q.pop_front() : 64'hDEAD;
        chk("m_req", m_bus_req, e);
        k++;
      end
      if (cl ? c1_respcyc : c0_respcyc) begin
        e = rsp_q.size() != 0 ? rsp_q.pop_front() : 64'hDEAD;
        chk("resp", cl ? c1_resp : c0_resp, e);
        if (r == 0) chk("rtag", cl ? c1_resptag : c0_resptag, RTAG);
        r++;
      end
      @(negedge clk);
      n++;
    end
    drv(cl, 1'b0, '0, '0, 1'b0);
    m_bus_respcyc = 0; m_bus_reqack = 0;
    #2;
    chk("beats", wr ? k : r, wr ? 9 : 8);
    chk("busy_end", busy, 0);
    chk("owner", owner, cl);
    chk("hs_vio", vio, 0);
    if (cl) gc1++; else gc0++;
  endtask

  initial begin
    idle_all();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_bus_respcyc = 1'b1; c0_respack = 1'b1;
    #2;
    chk("rst_busy0", busy, 0);
    chk("rst_owner0", owner, 1);
    chk("rst_mcyc0", m_bus_reqcyc, 0);
    chk("idle_rack", m_bus_respack, 0);
    chk("idle_c0rc", c0_respcyc, 0);
    idle_all();
    @(negedge clk);

    xact(0, 0, 64'h40, 64'h10, 0, -1, -1);
    xact(1, 1, 64'h1000, 64'hA0, 1, -1, -1);

    xact(0, 0, 64'h100, 64'h200, 0, 0, -1);
    xact(1, 0, 64'h110, 64'h300, 0, 0, -1);
    xact(0, 1, 64'h120, 64'h400, 0, 0, -1);
    xact(1, 0, 64'h130, 64'h500, 0, -1, -1);

    xact(0, 0, 64'h600, 64'h700, 0, 3, -1);
    xact(1, 0, 64'h610, 64'h800, 0, -1, -1);

    xact(0, 1, 64'h900, 64'hB0, 0, -1, 5);
    xact(1, 0, 64'h910, 64'hC0, 0, -1, -1);

    drv(0, 1'b1, 64'h300, TAG_RD, 1'b1);
    #2;
    chk("ab_idle", m_bus_reqcyc, 0);
    @(negedge clk);
    #2;
    chk("ab_req", m_bus_reqcyc, 1);
    chk("ab_addr", m_bus_req, 64'h300);
    drv(0, 1'b0, '0, '0, 1'b0);
    #2;
    chk("ab_drop", m_bus_reqcyc, 0);
    @(negedge clk);
    #2;
    chk("ab_busy", busy, 0);
    xact(0, 0, 64'h310, 64'hD0, 0, -1, -1);

`ifdef MEM_BUS_ARB_PERF_EN
    chk("gcnt0", grant_cnt0, gc0);
    chk("gcnt1", grant_cnt1, gc1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
